// File: rtl/csa_accumulate_sequencer.sv
// rtl/csa_accumulate_sequencer.sv - multi-operand carry-save accumulator with single resolve step
module csa_accumulate_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 20,
    parameter int MAX_OPS = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  op_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   s_reg;
    logic [ACC_W-1:0]   c_reg;
    logic [ACC_W-1:0]   result;
    logic [CNT_W-1:0]   remaining;

    logic               count_ok;
    logic               job_start;
    logic               bad_start;
    logic               accept;
    logic               last_op;
    logic [ACC_W-1:0]   x_ext;
    logic [ACC_W-1:0]   s_next;
    logic [ACC_W-1:0]   c_next;

    // An op_count of zero or above MAX_OPS is rejected; abort masks any start.
    assign count_ok  = (op_count != '0) && (op_count <= CNT_W'(MAX_OPS));
    assign job_start = (state == IDLE) && start && count_ok && !abort;
    assign bad_start = (state == IDLE) && start && !count_ok && !abort;
    assign accept    = (state == ACCUM) && in_valid;
    assign last_op   = (remaining == CNT_W'(1));

    // One 3:2 compressor row: the new operand is folded into the redundant pair.
    assign x_ext  = ACC_W'(in_data);
    assign s_next = s_reg ^ c_reg ^ x_ext;
    assign c_next = ((s_reg & c_reg) | (s_reg & x_ext) | (c_reg & x_ext)) << 1;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other input.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (job_start) state_next = ACCUM;
                ACCUM:   if (accept && last_op) state_next = RESOLVE;
                RESOLVE: state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    ;
            ACCUM:   begin in_ready = 1'b1; busy = 1'b1; end
            RESOLVE: busy = 1'b1;
            DONE:    begin out_valid = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // Datapath: redundant accumulator, operand countdown and resolved result.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            s_reg     <= '0;
            c_reg     <= '0;
            result    <= '0;
            remaining <= '0;
        end else begin
            if (job_start) begin
                s_reg     <= '0;
                c_reg     <= '0;
                remaining <= op_count;
            end else if (accept) begin
                s_reg     <= s_next;
                c_reg     <= c_next;
                remaining <= remaining - CNT_W'(1);
            end
            if (state == RESOLVE) begin
                result <= s_reg + c_reg;
            end
        end
    end

    // Error pulse registered one cycle after an illegal start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= bad_start;
        end
    end

    assign out_sum = result;

endmodule

// File: doc/csa_accumulate_sequencer.md
# csa_accumulate_sequencer

Sequential multi-operand adder controller for the Wallace-tree datapath. It streams up to 16 unsigned 16-bit operands through a single registered 3:2 carry-save stage, one operand per cycle, keeping the running result in redundant sum/carry form. It then performs one carry-propagate resolution and presents a 20-bit result on a valid/ready output. It is the block that schedules and sequences the carry-save hardware for the multiplier and accumulator paths.

## Interface
- DATA_W, 16, operand width (unsigned).
- ACC_W, 20, accumulator/result width; must be ≥ DATA_W + log2(MAX_OPS).
- MAX_OPS, 16, maximum operands per job.
- CNT_W, 5, width of op_count.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
- start  in  1  job request; sampled only in IDLE.
- op_count  in  CNT_W  operands in this job; sampled with start.
- abort  in  1  cancel the current job from any state.
- in_valid  in  1  operand valid.
- in_data  in  DATA_W  operand, zero-extended to ACC_W.
- in_ready  out  1  operand accepted when in_valid && in_ready.
- out_valid  out  1  result valid.
- out_sum  out  ACC_W  resolved sum.
- out_ready  in  1  result consumed when out_valid && out_ready.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on an illegal op_count.

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE. Internal registers: S, C (ACC_W each), remaining (CNT_W), result (ACC_W).
- IDLE:
  - start with 1 ≤ op_count ≤ MAX_OPS: S = 0, C = 0, remaining = op_count, go to ACCUM.
  - start with op_count = 0 or > MAX_OPS: err = 1 for one cycle, stay in IDLE, no other state change.
- ACCUM: in_ready = 1. On each transfer, with x = zero-extended in_data:
  - S' = S ^ C ^ x.
  - C' = ((S&C | S&x | C&x) << 1), truncated to ACC_W.
  - remaining decrements by 1.
  - When the transfer consumes the last operand (remaining == 1), go to RESOLVE.
  - in_valid low: S, C and remaining hold; no timeout.
- RESOLVE: result = S + C (ACC_W, carry-out discarded; it cannot be nonzero within limits). Go to DONE.
- DONE: out_valid = 1, out_sum = result, held stable until out_ready; on the handshake go to IDLE.
- start is ignored outside IDLE, and never errors there.
- abort: the next state is IDLE from any state. out_valid and in_ready are low the next cycle. S, C and result are cleared. abort has priority over every other input. abort in IDLE is a no-op.
- in_ready is low in IDLE, RESOLVE and DONE. Data presented then is not consumed.
- Arithmetic is unsigned modulo 2^ACC_W. With defaults, the maximum sum is 16 × 65535 = 1048560 < 2^20, so no overflow is possible.

## Timing
- Reset (rst_n low at an edge):
  - State is IDLE.
  - in_ready, out_valid, busy and err are 0.
  - out_sum, S, C, result and remaining are 0.
  - Reset mid-job discards the job with no output.
- Cycle counts:
  - start accepted at edge t: busy and in_ready are high from t+1.
  - Last operand accepted at edge t: RESOLVE during t+1, out_valid high from t+2.
  - Minimum job length with back-to-back operands: N + 2 cycles from the first in_ready to out_valid.
- in_ready is a registered state decode and does not depend combinationally on in_valid.
- Outputs are registered or pure state decodes; there is no combinational path from any input to any output.
- out_ready high on the first DONE cycle: IDLE on the next cycle. The earliest new start is sampled that IDLE cycle.
- err is high exactly one cycle after the offending start edge.

## Test plan
- Reset: hold rst_n low for 2 cycles with random inputs. Required: all outputs 0 and state IDLE. A start with rst_n low is ignored.
- Basic job: op_count = 4, operands 1, 2, 3, 4 back-to-back, out_ready = 1. Required:
  - out_sum = 10.
  - out_valid exactly 2 cycles after the last accept, for one cycle.
  - busy drops the following cycle.
- Full-scale job: op_count = 16, all operands 0xFFFF. Required: out_sum = 0xFFFF0 (1048560) and no truncation.
- Backpressure and gaps: op_count = 3, operands 0x1234, 0x00FF, 0x8000 with in_valid idle cycles between them; hold out_ready low for 5 cycles. Required:
  - in_ready held through the gaps.
  - out_sum = 0x9333, stable while out_valid is high.
  - Release happens on the first out_ready.
- Illegal count and stray start: start with op_count = 0, then 17. Required: one-cycle err each time and busy stays 0. A start during ACCUM leaves remaining unchanged.
- Abort and recovery:
  - op_count = 5, abort after 2 operands. Required: IDLE on the next cycle, out_valid never asserted.
  - Then op_count = 2, operands 5 and 7. Required: out_sum = 12.
  - Repeat with rst_n pulsed in place of abort; same result required.
